coax_tx_drain: RTL and testbench

//   Drains a coax_buffer holding queued 10-bit 3270 coax words and feeds them,
//   one word at a time, to the coax transmitter.

---
 rtl/coax_tx_drain.sv | 119 +++++++++++
 tb/tb_coax_tx_drain.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/coax_tx_drain.sv
// Drains queued 10-bit coax words from coax_buffer into coax_tx as one back-to-back message.
// Reports completion once the line has gone idle; error flags overflow or abort.
module coax_tx_drain #(
  parameter int MAX_WORDS   = 1024,
  parameter int COUNT_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [9:0]             buffer_read_data,
  input  logic                   buffer_empty,
  output logic                   buffer_read_strobe,
  output logic [9:0]             tx_data,
  output logic                   tx_load,
  input  logic                   tx_ready,
  input  logic                   tx_active,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] word_count
);

  typedef enum logic [2:0] {
    IDLE, READ, WAIT_DATA, OFFER, FLUSH, DONE
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] MAX_CNT = COUNT_WIDTH'(MAX_WORDS);

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [9:0]             data_q, data_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    count_d            = count_q;
    data_d             = data_q;
    err_d              = err_q;
    buffer_read_strobe = 1'b0;
    tx_load            = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          count_d = '0;
          err_d   = 1'b0;
          state_d = buffer_empty ? DONE : READ;
        end
      end
      READ: begin
        // Buffer drained underneath us: finish with whatever was already sent.
        if (buffer_empty) begin
          state_d = FLUSH;
        end else begin
          buffer_read_strobe = 1'b1;
          state_d            = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        data_d  = buffer_read_data;
        state_d = OFFER;
      end
      OFFER: begin
        if (tx_ready) begin
          tx_load = 1'b1;
          count_d = count_q + 1'b1;
          if (count_d == MAX_CNT && !buffer_empty) begin
            err_d   = 1'b1;
            state_d = FLUSH;
          end else if (!buffer_empty) begin
            state_d = READ;
          end else begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (!tx_active && tx_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides everything outside IDLE; a popped-but-unloaded word is dropped.
    if (abort && state_q != IDLE) begin
      state_d            = IDLE;
      err_d              = 1'b1;
      count_d            = count_q;
      data_d             = data_q;
      buffer_read_strobe = 1'b0;
      tx_load            = 1'b0;
    end
  end

  assign done_d     = (state_q == DONE) && !abort;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign error      = err_q;
  assign tx_data    = data_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_coax_tx_drain.sv
// Directed bench for coax_tx_drain with a small buffer model and transmitter model.
module tb_coax_tx_drain;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [9:0]  buffer_read_data = '0;
  logic        buffer_empty;
  logic        buffer_read_strobe;
  logic [9:0]  tx_data;
  logic        tx_load;
  logic        tx_ready;
  logic        tx_active;
  logic        busy;
  logic        done;
  logic        error;
  logic [10:0] word_count;

  coax_tx_drain #(.MAX_WORDS(4), .COUNT_WIDTH(11)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .buffer_read_data(buffer_read_data), .buffer_empty(buffer_empty),
    .buffer_read_strobe(buffer_read_strobe), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .tx_active(tx_active), .busy(busy), .done(done),
    .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  logic [9:0] buf_q[$];
  logic [9:0] sent_q[$];
  int         strobe_cnt = 0, load_cnt = 0, done_cnt = 0;
  int         act_cnt = 0;
  logic       ready_en = 1'b1;
  logic       bad_strobe = 1'b0, done_while_active = 1'b0;
  int         total = 0, fails = 0;

  assign buffer_empty = (buf_q.size() == 0);
  assign tx_active    = (act_cnt != 0);
  assign tx_ready     = ready_en;

  always @(posedge clk) begin
    if (buffer_read_strobe) begin
      if (buffer_empty) bad_strobe = 1'b1;
      else buffer_read_data = buf_q.pop_front();
      strobe_cnt++;
    end
    if (tx_load) begin
      sent_q.push_back(tx_data);
      load_cnt++;
      act_cnt = 4;
    end else if (act_cnt != 0) begin
      act_cnt--;
    end
    if (done) begin
      done_cnt++;
      if (tx_active) done_while_active = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 500) begin
      step();
      n++;
    end
    step();
    chk({tag, "_timeout"}, 32'(n < 500), 32'd1);
  endtask

  initial begin
    int d0, l0, s0;
    logic [9:0] held;
    logic stable;

    step(2);
    chk("reset_outputs", {buffer_read_strobe, tx_load, busy, done, error, tx_data, word_count},
        32'd0);
    reset = 1'b1;
    step();

    // 1: three-word message
    buf_q = '{10'h155, 10'h2AA, 10'h001};
    sent_q.delete();
    d0 = done_cnt;
    pulse_start();
    wait_idle("t1");
    chk("t1_loads", 32'(sent_q.size()), 32'd3);
    chk("t1_w0", 32'(sent_q[0]), 32'h155);
    chk("t1_w1", 32'(sent_q[1]), 32'h2AA);
    chk("t1_w2", 32'(sent_q[2]), 32'h001);
    chk("t1_count", 32'(word_count), 32'd3);
    chk("t1_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t1_done_line_idle", 32'(done_while_active), 32'd0);
    chk("t1_error", 32'(error), 32'd0);

    // 2: empty message still completes, two cycles after start
    step(6);
    s0 = strobe_cnt; l0 = load_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t2_done_1cyc", 32'(done), 32'd0);
    step();
    chk("t2_done_2cyc", 32'(done), 32'd1);
    step();
    chk("t2_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    chk("t2_no_load", 32'(load_cnt - l0), 32'd0);
    chk("t2_count", 32'(word_count), 32'd0);
    chk("t2_bad_strobe", 32'(bad_strobe), 32'd0);

    // 3: overflow at MAX_WORDS=4 with 6 queued
    buf_q = '{10'h010, 10'h020, 10'h030, 10'h040, 10'h050, 10'h060};
    l0 = load_cnt; d0 = done_cnt;
    pulse_start();
    wait_idle("t3");
    chk("t3_loads", 32'(load_cnt - l0), 32'd4);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_done", 32'(done_cnt - d0), 32'd1);
    chk("t3_left", 32'(buf_q.size()), 32'd2);
    chk("t3_count", 32'(word_count), 32'd4);
    buf_q.delete();

    // 4: stalled transmitter holds the word
    step(6);
    buf_q = '{10'h3C3, 10'h0F0};
    ready_en = 1'b0;
    l0 = load_cnt; s0 = strobe_cnt;
    pulse_start();
    step(3);
    held = tx_data;
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tx_data !== held || tx_load !== 1'b0) stable = 1'b0;
    end
    chk("t4_held_word", 32'(held), 32'h3C3);
    chk("t4_stable", 32'(stable), 32'd1);
    chk("t4_no_load", 32'(load_cnt - l0), 32'd0);
    chk("t4_one_strobe", 32'(strobe_cnt - s0), 32'd1);
    ready_en = 1'b1;
    #1;
    chk("t4_load_on_ready", 32'(tx_load), 32'd1);
    wait_idle("t4");
    chk("t4_loads", 32'(load_cnt - l0), 32'd2);

    // 5: abort after the second load
    step(6);
    buf_q = '{10'h101, 10'h102, 10'h103, 10'h104, 10'h105};
    sent_q.delete();
    d0 = done_cnt;
    pulse_start();
    begin
      int n;
      n = 0;
      while (load_cnt - l0 < 4 && n < 100) begin
        step();
        n++;
      end
      chk("t5_wait_timeout", 32'(n < 100), 32'd1);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_error", 32'(error), 32'd1);
    chk("t5_count", 32'(word_count), 32'd2);
    step(8);
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t5_left", 32'(buf_q.size()), 32'd3);
    pulse_start();
    chk("t5_error_cleared", 32'(error), 32'd0);
    wait_idle("t5");
    chk("t5_sent", 32'(sent_q.size()), 32'd5);
    chk("t5_w2", 32'(sent_q[2]), 32'h103);
    chk("t5_w4", 32'(sent_q[4]), 32'h105);
    chk("t5_count2", 32'(word_count), 32'd3);

    // 6: reset during WAIT_DATA
    step(6);
    buf_q = '{10'h2F1, 10'h2F2};
    sent_q.delete();
    pulse_start();
    step();
    #1;
    reset = 1'b0;
    #1;
    chk("t6_reset_outputs", {buffer_read_strobe, tx_load, busy, done, error, tx_data, word_count},
        32'd0);
    step(2);
    reset = 1'b1;
    step();
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_left", 32'(buf_q.size()), 32'd1);
    pulse_start();
    wait_idle("t6");
    chk("t6_sent", 32'(sent_q.size()), 32'd1);
    chk("t6_w0", 32'(sent_q[0]), 32'h2F2);
    chk("t6_count", 32'(word_count), 32'd1);
    chk("final_bad_strobe", 32'(bad_strobe), 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
